alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Initiator-side sequencer for the 6-bit register-loaded ALU. It accepts one complete operation (op code, operand a, operand b) over a valid/ready handshake and serializes it onto the ALU's shared `en`/`sel`/`x` load bus, one field per cycle. It then captures the ALU's combinational result and flags into a result register and holds them until they are consumed. It sits between a request source (a switch/UART front end or a test driver) and the ALU top, and it is the only driver of that top's `en`, `sel` and `x` inputs.

## Interface
- `WIDTH`, 6, data width of operands, `x` and result.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_op` in 3: ALU op code (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, others give y=0 and zf=1).
- `req_a`, `req_b` in WIDTH: operands.
- `en` out 1: load-bus enable to the ALU top.
- `sel` out 2: load target (00 = f, 01 = a, 10 = b).
- `x` out WIDTH: load data. For the f load it carries `{0…0, op}`.
- `alu_y` in WIDTH, `alu_zf`/`alu_cf`/`alu_of` in 1: ALU outputs.
- `res_valid` out 1: result held.
- `res_ready` in 1: consumer takes the result.
- `res_y` out WIDTH, `res_zf`/`res_cf`/`res_of` out 1: captured result.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD_F, LOAD_A, LOAD_B, WAIT, DONE.
- `en`, `sel`, `x` and all `res_*` outputs are registered. `req_ready` = (state == IDLE).
- **IDLE**
  - On `req_valid & req_ready`, latch op, a and b.
  - Go to LOAD_F if the op cache is invalid or the latched op differs from the cached op. Otherwise go to LOAD_A.
- **LOAD_F**: en=1, sel=00, x={0,op}. Set the cache to op and mark it valid. Next state LOAD_A.
- **LOAD_A**: en=1, sel=01, x=a. Next state LOAD_B.
- **LOAD_B**: en=1, sel=10, x=b. Next state WAIT.
- **WAIT**
  - en=0, sel=00, x=0. The ALU registers now hold the new operands.
  - At the end of this cycle, capture `alu_y/zf/cf/of` into `res_*`.
  - Next state DONE.
- **DONE**
  - res_valid=1. `res_*` stay stable while `res_ready` is low.
  - On `res_ready`, res_valid drops on the next edge and the state returns to IDLE.
  - A new request is accepted no earlier than the cycle after the return to IDLE.
- No arithmetic is done in this block. Results are passed through bit-exact, and flag semantics belong to the ALU.
- Outside LOAD_* states, en=0 always. The sequencer never drives sel=11.

## Timing
- **Reset values**: state IDLE, en=0, sel=00, x=0, res_valid=0, res_y=0, res_zf=0, res_cf=0, res_of=0, busy=0, req_ready=1, op cache invalid.
- **Latency**, with the request accepted at the edge ending cycle T:
  - With f load: en high in T+1..T+3, capture at the edge ending T+4, res_valid=1 from T+5.
  - With cached op: en high in T+1..T+2, res_valid=1 from T+4.
- **Minimum request spacing**: 6 cycles with f load, 5 cycles with cached op. Achieved when `res_ready` is already high on the first DONE cycle.
- **Reset mid-operation**: `rst` high at an edge forces all reset values on that edge. The partial load is abandoned and the cache is invalidated, so the next request always performs LOAD_F. `req_valid` during `rst` is ignored.
- `req_*` inputs are sampled only at the accepting edge. Later changes have no effect.
- `res_ready` outside DONE has no effect.

## Test plan
- **Add wrap**: op=000, a=0x3F, b=0x01.
  - Bus shows sel 00/01/10 with x 0x00/0x3F/0x01 on three consecutive cycles.
  - res_y=0x00, zf=1, cf=1, of=0 at T+5.
- **Sub overflow**: op=001, a=0x20, b=0x01 → res_y=0x1F, zf=0, cf=0, of=1.
- **Op cache**: two back-to-back add requests (0x05+0x03, then 0x07+0x01).
  - Second request has no sel=00 cycle and res_valid rises at T+4.
  - Results: 0x08 with flags 0, then 0x08 with flags 0.
- **Backpressure**: hold res_ready=0 for 5 DONE cycles with req_valid=1 asserted.
  - res_valid stays 1, res_* stay stable, req_ready stays 0, en stays 0.
  - Request accepted only after res_ready=1.
- **Reset mid-load**: assert rst for one cycle during LOAD_A.
  - Next cycle: en=0, busy=0, res_valid=0.
  - Following add request starts with LOAD_F.
- **Unsupported op**: op=110, a=0x15, b=0x2A → res_y=0x00, zf=1, cf=0, of=0. The cache then holds 110.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Serializes one ALU request (op, a, b) onto the shared en/sel/x load bus,
// then captures the ALU result and holds it until the consumer takes it.
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             en,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zf,
  input  logic             alu_cf,
  input  logic             alu_of,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic             res_zf,
  output logic             res_cf,
  output logic             res_of,
  output logic             busy
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_F = 2'b00;
  localparam logic [SEL_W-1:0] SEL_A = 2'b01;
  localparam logic [SEL_W-1:0] SEL_B = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_F,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t           state_q, state_d;
  req_t             req_q, cur;
  logic             accept;
  logic [OP_W-1:0]  cache_op_q;
  logic             cache_valid_q;
  logic             en_d;
  logic [SEL_W-1:0] sel_d;
  logic [WIDTH-1:0] x_d;

  // Next state and next bus values; bus outputs are registered from state_d.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    en_d    = 1'b0;
    sel_d   = SEL_F;
    x_d     = '0;
    cur     = req_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          cur.op = req_op;
          cur.a  = req_a;
          cur.b  = req_b;
          if (!cache_valid_q || (cache_op_q != req_op)) state_d = S_LOAD_F;
          else                                           state_d = S_LOAD_A;
        end
      end
      S_LOAD_F: state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_WAIT;
      S_WAIT:   state_d = S_DONE;
      S_DONE:   if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    case (state_d)
      S_LOAD_F: begin
        en_d  = 1'b1;
        sel_d = SEL_F;
        x_d   = WIDTH'(cur.op);
      end
      S_LOAD_A: begin
        en_d  = 1'b1;
        sel_d = SEL_A;
        x_d   = cur.a;
      end
      S_LOAD_B: begin
        en_d  = 1'b1;
        sel_d = SEL_B;
        x_d   = cur.b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_q         <= '0;
      cache_op_q    <= '0;
      cache_valid_q <= 1'b0;
      en            <= 1'b0;
      sel           <= SEL_F;
      x             <= '0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      res_y         <= '0;
      res_zf        <= 1'b0;
      res_cf        <= 1'b0;
      res_of        <= 1'b0;
    end else begin
      state_q   <= state_d;
      en        <= en_d;
      sel       <= sel_d;
      x         <= x_d;
      req_ready <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE);

      if (accept) req_q <= cur;

      // The f register now holds this op, so later identical ops skip LOAD_F.
      if (state_q == S_LOAD_F) begin
        cache_op_q    <= req_q.op;
        cache_valid_q <= 1'b1;
      end

      if (state_q == S_WAIT) begin
        res_y     <= alu_y;
        res_zf    <= alu_zf;
        res_cf    <= alu_cf;
        res_of    <= alu_of;
        res_valid <= 1'b1;
      end else if ((state_q == S_DONE) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: a register-loaded ALU stub on the
// load bus, and a request-level reference model for results, bus order and latency.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [2:0] req_op;
  logic [5:0] req_a, req_b;
  logic       en;
  logic [1:0] sel;
  logic [5:0] x;
  logic [5:0] alu_y;
  logic       alu_zf, alu_cf, alu_of;
  logic       res_valid, res_ready;
  logic [5:0] res_y;
  logic       res_zf, res_cf, res_of;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  bit         m_cache_valid;
  logic [2:0] m_cache_op;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .en(en), .sel(sel), .x(x),
    .alu_y(alu_y), .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_of(alu_of),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_zf(res_zf), .res_cf(res_cf), .res_of(res_of),
    .busy(busy)
  );

  // Reference ALU on whole integers: returns {y, zf, cf, of}.
  function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [5:0] a,
                                         input logic [5:0] b);
    int ua, ub, sa, sb, r, sr;
    logic [5:0] y;
    logic cf, of;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32) ? ua - 64 : ua;
    sb = (ub >= 32) ? ub - 64 : ub;
    cf = 1'b0;
    of = 1'b0;
    case (op)
      3'd0: begin
        r = ua + ub; sr = sa + sb;
        y = 6'(r); cf = (r > 63); of = (sr > 31) || (sr < -32);
      end
      3'd1: begin
        r = ua - ub; sr = sa - sb;
        y = 6'(r); cf = (r < 0); of = (sr > 31) || (sr < -32);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = ~a;
      default: y = 6'd0;
    endcase
    return {y, (y == 6'd0), cf, of};
  endfunction

  // ALU top stub: f/a/b registers loaded from the bus, combinational outputs.
  logic [2:0] f_r;
  logic [5:0] a_r, b_r;
  always_ff @(posedge clk) begin
    if (en) begin
      case (sel)
        2'd0: f_r <= x[2:0];
        2'd1: a_r <= x;
        2'd2: b_r <= x;
        default: ;
      endcase
    end
  end
  always_comb {alu_y, alu_zf, alu_cf, alu_of} = alu_ref(f_r, a_r, b_r);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge, check bus, latency, result and backpressure.
  task automatic run_req(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b,
                         input int hold, input bit keep_valid, output logic [8:0] res);
    bit         fl, seen;
    int         n, k, idx;
    logic [8:0] exp, held, eb;
    logic [5:0] xv;
    exp = alu_ref(op, a, b);
    fl  = !m_cache_valid || (m_cache_op != op);
    n   = fl ? 3 : 2;
    res = '0;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    m_cache_valid = 1'b1;
    m_cache_op = op;
    seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      if (res_valid) begin
        seen = 1'b1;
        check("latency", 32'(i), fl ? 32'd5 : 32'd4);
      end else begin
        if (i <= n) begin
          idx = fl ? i : i + 1;
          xv  = (idx == 1) ? {3'b000, op} : (idx == 2) ? a : b;
          eb  = {1'b1, 2'(idx - 1), xv};
        end else begin
          eb = 9'd0;
        end
        check("bus", 32'({busy, req_ready, en, sel, x}), 32'({2'b10, eb}));
        req_op = 3'($urandom); req_a = 6'($urandom); req_b = 6'($urandom);
        res_ready = (hold == 0) ? 1'($urandom) : 1'b0;
        @(negedge clk);
      end
    end
    if (!seen) begin
      check("res_valid_timeout", 32'd0, 32'd1);
    end else begin
      held = {res_y, res_zf, res_cf, res_of};
      res  = held;
      check("result", 32'(held), 32'(exp));
      check("done_bus", 32'({busy, req_ready, en, sel, x}), 32'({2'b10, 9'd0}));
      res_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        req_valid = keep_valid;
        if (keep_valid) begin
          req_op = 3'($urandom); req_a = 6'($urandom); req_b = 6'($urandom);
        end
        @(negedge clk);
        check("hold", 32'({res_valid, res_y, res_zf, res_cf, res_of, busy, req_ready, en}),
              32'({1'b1, held, 3'b100}));
      end
      res_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      res_ready = 1'b0;
      check("release", 32'({res_valid, busy, req_ready, en}), 32'(4'b0010));
    end
  endtask

  // Start a request and pulse rst during its LOAD_A cycle, with req_valid high.
  task automatic reset_mid(input logic [2:0] op, input logic [5:0] a, input logic [5:0] b);
    bit fl;
    int k;
    fl = !m_cache_valid || (m_cache_op != op);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (fl) @(negedge clk);
    check("pre_reset_load_a", 32'({en, sel, x}), 32'({1'b1, 2'b01, a}));
    rst = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    check("post_reset", 32'({en, sel, x, busy, res_valid, req_ready}),
          32'({1'b0, 2'b00, 6'd0, 3'b001}));
    rst = 1'b0;
    req_valid = 1'b0;
    m_cache_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] r;
    logic [2:0] op;
    rst = 1'b1;
    req_valid = 1'b1;
    res_ready = 1'b0;
    req_op = 3'd2; req_a = 6'h11; req_b = 6'h22;
    m_cache_valid = 1'b0;
    m_cache_op = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_bus", 32'({en, sel, x}), 32'd0);
    check("reset_ctl", 32'({busy, req_ready, res_valid}), 32'(3'b010));
    check("reset_res", 32'({res_y, res_zf, res_cf, res_of}), 32'd0);
    rst = 1'b0;
    req_valid = 1'b0;

    run_req(3'd0, 6'h3F, 6'h01, 0, 1'b0, r);
    check("add_wrap", 32'(r), 32'({6'h00, 3'b110}));
    run_req(3'd1, 6'h20, 6'h01, 0, 1'b0, r);
    check("sub_overflow", 32'(r), 32'({6'h1F, 3'b001}));
    run_req(3'd0, 6'h05, 6'h03, 0, 1'b0, r);
    check("cache_first", 32'(r), 32'({6'h08, 3'b000}));
    run_req(3'd0, 6'h07, 6'h01, 0, 1'b0, r);
    check("cache_second", 32'(r), 32'({6'h08, 3'b000}));
    run_req(3'd0, 6'h2A, 6'h11, 5, 1'b1, r);
    run_req(3'd2, 6'h3C, 6'h0F, 0, 1'b0, r);

    reset_mid(3'd2, 6'h0C, 6'h21);
    run_req(3'd0, 6'h01, 6'h02, 0, 1'b0, r);

    run_req(3'd6, 6'h15, 6'h2A, 0, 1'b0, r);
    check("unsupported_op", 32'(r), 32'({6'h00, 3'b100}));
    run_req(3'd6, 6'h01, 6'h02, 0, 1'b0, r);

    op = 3'd0;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) op = 3'($urandom);
      if ($urandom_range(0, 7) == 0)
        reset_mid(op, 6'($urandom), 6'($urandom));
      else
        run_req(op, 6'($urandom), 6'($urandom), $urandom_range(0, 3),
                1'($urandom), r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
